// File: rtl/decode_cycle.sv
// RV32 decode stage: control decode, immediate extension, 32x32 register file and ID/EX register.
// Optional macro WB_BYPASS_EN: register-file reads see a same-cycle writeback (write-through).
module decode_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic        ALUSrcE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E
);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_e;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0]  result_src_d;
  alu_e        alu_ctrl_d, alu_arith;
  logic [31:0] imm_ext_d;
  logic [31:0] rd1_d, rd2_d;
  logic [31:0] regs [32];
  logic        wb_en;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rs1    = InstrD[19:15];
  assign rs2    = InstrD[24:20];
  assign rd     = InstrD[11:7];
  assign wb_en  = RegWriteW && (RDW != 5'd0);

  // funct7[5] only selects sub for register-register ops; for I-ALU it is immediate data.
  always_comb begin
    alu_arith = ALU_ADD;
    case (funct3)
      3'b000:  if (opcode == OP_RTYPE && InstrD[30]) alu_arith = ALU_SUB;
      3'b010:  alu_arith = ALU_SLT;
      3'b110:  alu_arith = ALU_OR;
      3'b111:  alu_arith = ALU_AND;
      default: alu_arith = ALU_ADD;
    endcase
  end

  always_comb begin
    reg_write_d  = 1'b0;
    result_src_d = 2'b00;
    mem_write_d  = 1'b0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    alu_src_d    = 1'b0;
    alu_ctrl_d   = ALU_ADD;
    imm_ext_d    = '0;
    case (opcode)
      OP_LOAD: begin
        reg_write_d  = 1'b1;
        result_src_d = 2'b01;
        alu_src_d    = 1'b1;
        imm_ext_d    = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_STORE: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_ext_d   = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OP_RTYPE: begin
        reg_write_d = 1'b1;
        alu_ctrl_d  = alu_arith;
      end
      OP_IALU: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_ctrl_d  = alu_arith;
        imm_ext_d   = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_BRANCH: begin
        branch_d   = 1'b1;
        alu_ctrl_d = ALU_SUB;
        imm_ext_d  = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      OP_JAL: begin
        reg_write_d  = 1'b1;
        result_src_d = 2'b10;
        jump_d       = 1'b1;
        imm_ext_d    = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // x0 is never written, so regs[0] stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      regs <= '{default: '0};
    else if (wb_en)
      regs[RDW] <= ResultW;
  end

  always_comb begin
    rd1_d = regs[rs1];
    rd2_d = regs[rs2];
`ifdef WB_BYPASS_EN
    if (wb_en && RDW == rs1) rd1_d = ResultW;
    if (wb_en && RDW == rs2) rd2_d = ResultW;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= '0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= '0;
      ALUSrcE     <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      if (FlushE) begin
        RegWriteE   <= 1'b0;
        ResultSrcE  <= '0;
        MemWriteE   <= 1'b0;
        JumpE       <= 1'b0;
        BranchE     <= 1'b0;
        ALUControlE <= '0;
        ALUSrcE     <= 1'b0;
      end else begin
        RegWriteE   <= reg_write_d;
        ResultSrcE  <= result_src_d;
        MemWriteE   <= mem_write_d;
        JumpE       <= jump_d;
        BranchE     <= branch_d;
        ALUControlE <= alu_ctrl_d;
        ALUSrcE     <= alu_src_d;
      end
      RD1E     <= rd1_d;
      RD2E     <= rd2_d;
      ImmExtE  <= imm_ext_d;
      Rs1E     <= rs1;
      Rs2E     <= rs2;
      RdE      <= rd;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
    end
  end

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 The block SHALL have ports clk (in, 1, sole clock, rising edge) and rst (in, 1, asynchronous, active-high reset).
REQ-002 InstrD (in, 32), PCD (in, 32) and PCPlus4D (in, 32) SHALL carry the instruction, PC and PC+4 from the fetch stage.
REQ-003 RegWriteW (in, 1), RDW (in, 5) and ResultW (in, 32) SHALL form the writeback port: enable, destination register and data.
REQ-004 FlushE (in, 1) SHALL squash the instruction entering execute.
REQ-005 Control outputs SHALL be RegWriteE (1), ResultSrcE (2), MemWriteE (1), JumpE (1), BranchE (1), ALUControlE (3) and ALUSrcE (1).
REQ-006 Datapath outputs SHALL be RD1E (32), RD2E (32), ImmExtE (32), Rs1E (5), Rs2E (5), RdE (5), PCE (32) and PCPlus4E (32).

Function
REQ-007 Supported opcodes SHALL be lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011 and jal 1101111.
REQ-008 Any other opcode SHALL decode to all control outputs zero (bubble).
REQ-009 ResultSrc SHALL be 00 ALU, 01 memory, 10 PC+4; it is 01 for lw, 10 for jal and 00 otherwise.
REQ-010 ALUControl SHALL be 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-011 lw, sw and jal SHALL use add, and beq SHALL use sub.
REQ-012 R-type and I-ALU SHALL decode funct3 as 000 add (R-type with funct7[5]=1 is sub), 010 slt, 110 or, 111 and.
REQ-013 Immediates SHALL be sign-extended from bit 31 in I, S, B (bit0=0) and J (bit0=0) formats, selected by opcode; R-type ImmExt SHALL be 0.
REQ-014 Rs1=InstrD[19:15], Rs2=InstrD[24:20], Rd=InstrD[11:7], passed through unconditionally.
REQ-015 The register file SHALL hold 32x32 entries and have two combinational read ports addressed by Rs1/Rs2.
REQ-016 The register file SHALL have one write port, written on the rising clk edge when RegWriteW=1 and RDW!=0.
REQ-017 x0 SHALL always read 0, and writes to x0 SHALL be ignored.
REQ-018 All E outputs SHALL be registered (ID/EX register) and reflect the D-side values one clk after presentation (latency 1).
REQ-019 FlushE=1 at a rising edge SHALL load zero into RegWriteE, MemWriteE, JumpE, BranchE, ResultSrcE and ALUControlE.
REQ-020 Under FlushE=1, datapath E outputs SHALL still load normally.
REQ-021 A writeback and a read of the same register in the same cycle SHALL follow REQ-029 / REQ-030.

Reset
REQ-022 While rst=1, every E output SHALL be 0 immediately, independent of clk.
REQ-023 While rst=1, all 32 register-file entries SHALL be cleared to 0.
REQ-024 Reset asserted mid-operation SHALL discard the in-flight ID/EX contents and any same-cycle writeback.
REQ-025 The first valid capture SHALL occur on the first rising edge after rst deasserts.

Configuration
REQ-026 The macro WB_BYPASS_EN SHALL control register-file internal write-through.
REQ-027 With WB_BYPASS_EN defined, a read port whose address equals RDW SHALL return ResultW in the same cycle when RegWriteW=1 and RDW!=0.
REQ-028 Without WB_BYPASS_EN, a read port SHALL return the stored value, so a write in cycle N becomes visible to reads in cycle N+1.
REQ-029 With WB_BYPASS_EN defined, a same-cycle write and read of one register SHALL return the new data.
REQ-030 Without WB_BYPASS_EN, a same-cycle write and read of one register SHALL return the old data.

Verification
REQ-031 InstrD=0x00500093 (addi x1,x0,5) -> next edge: RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=5, Rs1E=0, RdE=1, ResultSrcE=00.
REQ-032 Write x5=0xDEADBEEF, then InstrD=0x00528333 (add x6,x5,x5) -> RD1E=RD2E=0xDEADBEEF, ALUSrcE=0, RdE=6.
REQ-033 InstrD=0xFE20AE23 (sw x2,-4(x1)) -> MemWriteE=1, RegWriteE=0, ImmExtE=0xFFFFFFFC, ALUSrcE=1.
REQ-034 RegWriteW=1, RDW=0, ResultW=0x12345678, then read x0 -> RD1E=0.
REQ-035 Present addi with FlushE=1 -> all control outputs 0, and PCE equals PCD.
REQ-036 Same-cycle write x7=0xA5A5A5A5 with a read of x7 -> RD1E=0xA5A5A5A5 with WB_BYPASS_EN, previous value without it.
